pe_array_cfg_loader: RTL and testbench

- Upstream sequencer for the 4x4 PE array with its 4 top-row LSUs. It fetches a context of configuration entries from a synchronous config RAM and streams each one onto the array's PE_config bus with a one-cycle init_PE_array strobe.
- After the last entry it raises run for a programmed number of cycles, then pulses done.
- Sits between the host/control path and the PE array.

---
 rtl/pe_array_cfg_loader_pkg.sv | 29 ++
 rtl/pe_array_cfg_loader_cfg_fetch_pipe.sv | 73 +++++++
 rtl/pe_array_cfg_loader.sv | 129 ++++++++++++
 tb/tb_pe_array_cfg_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_cfg_loader_pkg.sv
// Shared widths, init-field layout and FSM encoding for the PE-array configuration loader.
package pe_array_cfg_loader_pkg;

    localparam int INIT_W        = 13;
    localparam int PE_INST_W_DEF = 16;
    localparam int ADDR_W_DEF    = 8;
    localparam int RUN_CNT_W_DEF = 16;
    localparam int ENTRY_W       = INIT_W + PE_INST_W_DEF;

    // init_PE_array layout: {lsu4..7, row_sel, lsu_pe_sel}
    localparam int INIT_LSU_LSB   = 9;
    localparam int INIT_LSU_W     = 4;
    localparam int INIT_ROW_LSB   = 5;
    localparam int INIT_ROW_W     = 4;
    localparam int INIT_PESEL_LSB = 0;
    localparam int INIT_PESEL_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    function automatic int entry_width(input int pe_inst_w);
        return INIT_W + pe_inst_w;
    endfunction

endpackage

// File: rtl/pe_array_cfg_loader_cfg_fetch_pipe.sv
// Config RAM read issue (address/count) and the return path that turns each
// returned entry into a one-cycle init strobe plus a held payload.
module cfg_fetch_pipe
    import pe_array_cfg_loader_pkg::*;
#(
    parameter int PE_INST_W = PE_INST_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_i,
    input  logic [ADDR_W-1:0]           base_i,
    input  logic [ADDR_W:0]             len_i,
    input  logic                        flush_i,
    output logic                        last_issue_o,
    output logic                        rd_en_o,
    output logic [ADDR_W-1:0]           rd_addr_o,
    input  logic [INIT_W+PE_INST_W-1:0] rd_data_i,
    output logic [INIT_W-1:0]           init_o,
    output logic [PE_INST_W-1:0]        payload_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic                 rd_en_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W:0]      rem_q;
    logic                 rd_vld_q;
    logic [INIT_W-1:0]    init_q;
    logic [PE_INST_W-1:0] payload_q;

    assign rd_en_o      = rd_en_q;
    assign rd_addr_o    = addr_q;
    assign init_o       = init_q;
    assign payload_o    = payload_q;
    assign last_issue_o = rd_en_q && (rem_q == CNT_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            rd_vld_q  <= 1'b0;
            init_q    <= '0;
            payload_q <= '0;
        end else begin
            if (flush_i) begin
                rd_en_q <= 1'b0;
            end else if (load_i) begin
                rd_en_q <= 1'b1;
                addr_q  <= base_i;
                rem_q   <= len_i;
            end else if (rd_en_q) begin
                // address register wraps naturally modulo 2^ADDR_W
                addr_q <= addr_q + ADDR_ONE;
                rem_q  <= rem_q - CNT_ONE;
                if (rem_q == CNT_ONE)
                    rd_en_q <= 1'b0;
            end

            // a flush kills both the read issued this cycle and the data returning now
            rd_vld_q <= rd_en_q && !flush_i;
            if (rd_vld_q && !flush_i) begin
                init_q    <= rd_data_i[INIT_W+PE_INST_W-1:PE_INST_W];
                payload_q <= rd_data_i[PE_INST_W-1:0];
            end else begin
                init_q    <= '0;
            end
        end
    end

endmodule

// File: rtl/pe_array_cfg_loader.sv
// Sequencer that streams a context of config entries onto the PE array, then
// holds run for a programmed number of cycles and reports done or aborted.
module pe_array_cfg_loader
    import pe_array_cfg_loader_pkg::*;
#(
    parameter int PE_INST_W = PE_INST_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RUN_CNT_W = RUN_CNT_W_DEF,
    parameter int ENTRY_W   = entry_width(PE_INST_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [ADDR_W:0]      cfg_len,
    input  logic [RUN_CNT_W-1:0] run_cycles,
    output logic                 cfg_rd_en,
    output logic [ADDR_W-1:0]    cfg_rd_addr,
    input  logic [ENTRY_W-1:0]   cfg_rd_data,
    output logic [INIT_W-1:0]    init_PE_array,
    output logic [PE_INST_W-1:0] PE_config,
    output logic                 run,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam logic [RUN_CNT_W-1:0] RUN_ONE = {{(RUN_CNT_W-1){1'b0}}, 1'b1};

    state_e               state_q;
    logic [RUN_CNT_W-1:0] run_cnt_q;
    logic                 drain_q;
    logic                 run_q;
    logic                 done_q;
    logic                 aborted_q;

    logic accept;
    logic kill;
    logic load_go;
    logic last_issue;

    // start only counts in IDLE; abort only counts when busy, so start wins in IDLE
    assign accept  = start && (state_q == ST_IDLE);
    assign kill    = abort && (state_q != ST_IDLE);
    assign load_go = accept && (cfg_len != '0);

    assign run     = run_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;

    cfg_fetch_pipe #(
        .PE_INST_W (PE_INST_W),
        .ADDR_W    (ADDR_W)
    ) u_fetch (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_go),
        .base_i       (cfg_base),
        .len_i        (cfg_len),
        .flush_i      (kill),
        .last_issue_o (last_issue),
        .rd_en_o      (cfg_rd_en),
        .rd_addr_o    (cfg_rd_addr),
        .rd_data_i    (cfg_rd_data[INIT_W+PE_INST_W-1:0]),
        .init_o       (init_PE_array),
        .payload_o    (PE_config)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            run_cnt_q <= '0;
            drain_q   <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (kill) begin
                state_q   <= ST_IDLE;
                run_q     <= 1'b0;
                drain_q   <= 1'b0;
                run_cnt_q <= '0;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            run_cnt_q <= run_cycles;
                            drain_q   <= 1'b0;
                            state_q   <= (cfg_len == '0) ? ST_DRAIN : ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (last_issue) begin
                            drain_q <= 1'b0;
                            state_q <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        // two cycles: last read's data returns, then lands on the outputs
                        if (drain_q) begin
                            drain_q <= 1'b0;
                            run_q   <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            drain_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // a zero count never reaches one, so run holds until abort
                        if (run_cnt_q == RUN_ONE) begin
                            run_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (run_cnt_q != '0) begin
                            run_cnt_q <= run_cnt_q - RUN_ONE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_array_cfg_loader.sv
// Directed bench for pe_array_cfg_loader: behavioural config RAM, cycle-by-cycle expectations.
module tb_pe_array_cfg_loader;

    localparam int PW = 16;
    localparam int AW = 8;
    localparam int RW = 16;
    localparam int EW = 13 + PW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] cfg_base;
    logic [AW:0]   cfg_len;
    logic [RW-1:0] run_cycles;
    logic          cfg_rd_en;
    logic [AW-1:0] cfg_rd_addr;
    logic [EW-1:0] cfg_rd_data;
    logic [12:0]   init_PE_array;
    logic [PW-1:0] PE_config;
    logic          run;
    logic          busy;
    logic          done;
    logic          aborted;

    logic [EW-1:0] mem [0:255];
    int n_checks = 0;
    int n_errors = 0;

    pe_array_cfg_loader #(
        .PE_INST_W (PW),
        .ADDR_W    (AW),
        .RUN_CNT_W (RW),
        .ENTRY_W   (EW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_base      (cfg_base),
        .cfg_len       (cfg_len),
        .run_cycles    (run_cycles),
        .cfg_rd_en     (cfg_rd_en),
        .cfg_rd_addr   (cfg_rd_addr),
        .cfg_rd_data   (cfg_rd_data),
        .init_PE_array (init_PE_array),
        .PE_config     (PE_config),
        .run           (run),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous RAM: data valid the cycle after the read enable
    always @(posedge clk) begin
        if (cfg_rd_en)
            cfg_rd_data <= mem[cfg_rd_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // check one cycle's outputs at the falling edge, then move to the next cycle
    task automatic cyc(input string tag, input logic en, input logic [AW-1:0] addr,
                       input logic [12:0] init, input logic r, input logic b,
                       input logic d, input logic a);
        chk({tag, ".rd_en"}, {31'd0, cfg_rd_en}, {31'd0, en});
        if (en)
            chk({tag, ".addr"}, {24'd0, cfg_rd_addr}, {24'd0, addr});
        chk({tag, ".init"}, {19'd0, init_PE_array}, {19'd0, init});
        chk({tag, ".run"}, {31'd0, run}, {31'd0, r});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
        chk({tag, ".aborted"}, {31'd0, aborted}, {31'd0, a});
        @(negedge clk);
    endtask

    initial begin
        int bad;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_base = '0; cfg_len = '0; run_cycles = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = {13'h020, 16'hA000};
        mem[8'h11] = {13'h040, 16'hA001};
        mem[8'h12] = {13'h080, 16'hA002};
        mem[8'hFE] = {13'h001, 16'hB0FE};
        mem[8'hFF] = {13'h002, 16'hB0FF};
        mem[8'h00] = {13'h004, 16'hB000};
        mem[8'h01] = {13'h1FFF, 16'hB001};
        mem[8'h20] = {13'h000, 16'hC020};
        mem[8'h21] = {13'h100, 16'hC021};
        for (int i = 0; i < 5; i++) mem[8'h30 + i] = {13'h011, 16'hD030 + 16'(i)};
        mem[8'h40] = {13'h003, 16'hE040};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.PE_config", {16'd0, PE_config}, 32'd0);
        cyc("rst", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // basic load: base 0x10, len 3, run 4
        cfg_base = 8'h10; cfg_len = 9'd3; run_cycles = 16'd4; start = 1'b1;
        cyc("basic.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("basic.T1", 1'b1, 8'h10, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("basic.T2", 1'b1, 8'h11, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("basic.cfg0", {16'd0, PE_config}, 32'hA000);
        cyc("basic.T3", 1'b1, 8'h12, 13'h020, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("basic.cfg1", {16'd0, PE_config}, 32'hA001);
        cyc("basic.T4", 1'b0, 8'h00, 13'h040, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("basic.cfg2", {16'd0, PE_config}, 32'hA002);
        cyc("basic.T5", 1'b0, 8'h00, 13'h080, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 6; k <= 9; k++)
            cyc($sformatf("basic.T%0d", k), 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic.cfg_hold", {16'd0, PE_config}, 32'hA002);
        cyc("basic.T10", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("basic.T11", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // address wrap: base 0xFE, len 4, run 1
        cfg_base = 8'hFE; cfg_len = 9'd4; run_cycles = 16'd1; start = 1'b1;
        cyc("wrap.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("wrap.T1", 1'b1, 8'hFE, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("wrap.T2", 1'b1, 8'hFF, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("wrap.T3", 1'b1, 8'h00, 13'h001, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("wrap.T4", 1'b1, 8'h01, 13'h002, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("wrap.T5", 1'b0, 8'h00, 13'h004, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap.cfg3", {16'd0, PE_config}, 32'hB001);
        cyc("wrap.T6", 1'b0, 8'h00, 13'h1FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("wrap.T7", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("wrap.T8", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // empty context: len 0, run 2
        cfg_len = 9'd0; run_cycles = 16'd2; start = 1'b1;
        cyc("empty.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("empty.T1", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("empty.T2", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("empty.T3", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("empty.T4", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("empty.cfg_hold", {16'd0, PE_config}, 32'hB001);
        cyc("empty.T5", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // NOP entry at 0x20 updates payload without a strobe
        cfg_base = 8'h20; cfg_len = 9'd2; run_cycles = 16'd1; start = 1'b1;
        cyc("nop.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("nop.T1", 1'b1, 8'h20, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("nop.T2", 1'b1, 8'h21, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("nop.cfg0", {16'd0, PE_config}, 32'hC020);
        cyc("nop.T3", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("nop.cfg1", {16'd0, PE_config}, 32'hC021);
        cyc("nop.T4", 1'b0, 8'h00, 13'h100, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("nop.T5", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("nop.T6", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // abort on the 2nd read of a len-5 context, then restart right away
        cfg_base = 8'h30; cfg_len = 9'd5; run_cycles = 16'd3; start = 1'b1;
        cyc("abl.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("abl.T1", 1'b1, 8'h30, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        cyc("abl.T2", 1'b1, 8'h31, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        abort = 1'b0;
        chk("abl.cfg_kept", {16'd0, PE_config}, 32'hC021);
        cfg_base = 8'h10; cfg_len = 9'd1; run_cycles = 16'd1; start = 1'b1;
        cyc("abl.T3", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        cyc("rst2.T1", 1'b1, 8'h10, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("rst2.T2", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst2.cfg", {16'd0, PE_config}, 32'hA000);
        cyc("rst2.T3", 1'b0, 8'h00, 13'h020, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("rst2.T4", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("rst2.T5", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // start and abort together in IDLE: start wins
        cfg_len = 9'd0; run_cycles = 16'd1; start = 1'b1; abort = 1'b1;
        cyc("sa.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0; abort = 1'b0;
        cyc("sa.T1", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("sa.T2", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("sa.T3", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("sa.T4", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // run_cycles=0 with an ignored start while running
        cfg_base = 8'h40; cfg_len = 9'd1; run_cycles = 16'd0; start = 1'b1;
        cyc("inf.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("inf.T1", 1'b1, 8'h40, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("inf.T2", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("inf.cfg", {16'd0, PE_config}, 32'hE040);
        cyc("inf.T3", 1'b0, 8'h00, 13'h003, 1'b0, 1'b1, 1'b0, 1'b0);
        cfg_base = 8'h50; cfg_len = 9'd2; run_cycles = 16'd5; start = 1'b1;
        cyc("inf.T4", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        cyc("inf.T5", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            if (run !== 1'b1 || done !== 1'b0 || cfg_rd_en !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("inf.hold_bad_cycles", bad, 32'd0);
        abort = 1'b1;
        cyc("inf.abort", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        abort = 1'b0;
        cyc("inf.after", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("inf.idle", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // abort on the last run cycle: aborted, no done
        cfg_len = 9'd0; run_cycles = 16'd2; start = 1'b1;
        cyc("al.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("al.T1", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("al.T2", 1'b0, 8'h00, 13'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("al.T3", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        cyc("al.T4", 1'b0, 8'h00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        abort = 1'b0;
        cyc("al.T5", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("al.T6", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of RUN
        cfg_len = 9'd0; run_cycles = 16'd0; start = 1'b1;
        cyc("ar.T0", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar.run_before", {31'd0, run}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar.run_now", {31'd0, run}, 32'd0);
        chk("ar.busy_now", {31'd0, busy}, 32'd0);
        chk("ar.init_now", {19'd0, init_PE_array}, 32'd0);
        chk("ar.cfg_now", {16'd0, PE_config}, 32'd0);
        @(negedge clk);
        cyc("ar.held", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        cyc("ar.release", 1'b0, 8'h00, 13'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
